riscvsys_evmon: RTL and testbench
=================================

RISCVSYS_EVMON -- requirements
Module: riscvsys_evmon

Interface
REQ-001 Parameter: CNT_W, default 32, width of retired-instruction counter.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-low.
REQ-004 i_instr_<m>  input  1 each  one-hot decode flags; 49 signals:
- m = lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lb, lh, lw, lbu, lhu, sb, sh, sw, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, srl, sra, or, and, rdcycle, rdcycleh, rdinstr, rdinstrh, ecall_ebreak, getq, setq, retirq, maskirq, waitirq, timer, trap.
REQ-005 i_pc  input  32  address of the instruction being decoded.
REQ-006 i_next_pc  input  32  core next-PC register; monitored, unused by logic.
REQ-007 i_dbg_next  input  1  qualifier: flags and i_pc describe a new instruction this cycle.
REQ-008 ev_<m>  output  1 each  per-mnemonic event pulse, same 49 names as REQ-004 (e.g. ev_add).
REQ-009 ev_branch, ev_jump, ev_load, ev_store, ev_alu, ev_csr, ev_irq  output  1 each  class events.
REQ-010 ev_nonseq  output  1  PC discontinuity event.
REQ-011 ev_onehot_err  output  1  more than one flag set on a qualified cycle.
REQ-012 ev_unknown  output  1  qualified cycle with no flag set.
REQ-013 o_instr_cnt  output  CNT_W  count of qualified cycles.

Function
REQ-014 All ev_* outputs registered; latency exactly 1 cycle after the qualifying i_clk edge sample; high for one cycle per qualified cycle.
REQ-015 ev_<m> = 1 in cycle N+1 iff i_dbg_next & i_instr_<m> in cycle N.
REQ-016 Flags with i_dbg_next=0 ignored; no event, no count.
REQ-017 Class membership: branch = beq..bgeu; jump = jal, jalr; load = lb, lh, lw, lbu, lhu; store = sb, sh, sw; alu = lui, auipc, addi..srai, add..and; csr = rdcycle, rdcycleh, rdinstr, rdinstrh; irq = getq, setq, retirq, maskirq, waitirq, timer.
- ecall_ebreak and trap belong to no class.
REQ-018 Class event = OR of member flags, qualified by i_dbg_next, same latency.
REQ-019 Simultaneous flags: every asserted ev_<m> and class event reported; ev_onehot_err=1 when popcount of flags > 1.
REQ-020 ev_unknown=1 when i_dbg_next=1 and all 49 flags are 0.
REQ-021 Internal last_pc (32b) and last_vld (1b): on each qualified cycle load last_pc <= i_pc, last_vld <= 1.
REQ-022 ev_nonseq=1 when last_vld=1 and (i_pc - last_pc) mod 2^32 is not 2 or 4; no nonseq on first qualified cycle after reset.
REQ-023 o_instr_cnt increments by 1 per qualified cycle, wraps from 2^CNT_W-1 to 0.

Reset
REQ-024 While i_rst=0 at a rising edge: all ev_* <= 0, o_instr_cnt <= 0, last_pc <= 0, last_vld <= 0.
REQ-025 Reset dominates: a qualified cycle coincident with reset produces no event and no count.
REQ-026 First event possible one cycle after the first qualified cycle following reset release.

Configuration
REQ-027 Macro RISCVSYS_EVMON_COUNT_EN: defined, o_instr_cnt implemented per REQ-023.
- Undefined: counter logic absent and o_instr_cnt tied to 0; all event outputs unchanged.

Verification
REQ-028 Reset release, then i_dbg_next=1, i_instr_add=1, i_pc=0x100 for one cycle -> next cycle ev_add=1, ev_alu=1, others 0; o_instr_cnt=1.
REQ-029 i_instr_beq=1 with i_dbg_next=0 -> no ev_* for 3 cycles; o_instr_cnt unchanged.
REQ-030 Qualified pcs 0x100, 0x104, 0x106, 0x200 -> ev_nonseq only on the event for 0x200; o_instr_cnt=4.
REQ-031 i_dbg_next=1 with i_instr_lw=1 and i_instr_sw=1 -> ev_lw, ev_sw, ev_load, ev_store, ev_onehot_err all 1; all flags 0 -> ev_unknown=1.
REQ-032 CNT_W=4, 17 qualified cycles -> o_instr_cnt=1; i_rst=0 asserted mid-stream with i_dbg_next=1 -> ev_*=0, o_instr_cnt=0 next cycle.
REQ-033 Build without RISCVSYS_EVMON_COUNT_EN, 5 qualified lw cycles -> o_instr_cnt=0; ev_lw pulses 5 times.

Source files
------------

// File: rtl/riscvsys_evmon.sv
// Instruction-event monitor: registered per-mnemonic and per-class event pulses,
// PC discontinuity detection and a retired-instruction counter (RISCVSYS_EVMON_COUNT_EN).
module riscvsys_evmon #(
    parameter int unsigned CNT_W = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_instr_lui, i_instr_auipc, i_instr_jal, i_instr_jalr,
    input  logic i_instr_beq, i_instr_bne, i_instr_blt, i_instr_bge, i_instr_bltu, i_instr_bgeu,
    input  logic i_instr_lb, i_instr_lh, i_instr_lw, i_instr_lbu, i_instr_lhu,
    input  logic i_instr_sb, i_instr_sh, i_instr_sw,
    input  logic i_instr_addi, i_instr_slti, i_instr_sltiu, i_instr_xori, i_instr_ori,
    input  logic i_instr_andi, i_instr_slli, i_instr_srli, i_instr_srai,
    input  logic i_instr_add, i_instr_sub, i_instr_sll, i_instr_slt, i_instr_sltu,
    input  logic i_instr_xor, i_instr_srl, i_instr_sra, i_instr_or, i_instr_and,
    input  logic i_instr_rdcycle, i_instr_rdcycleh, i_instr_rdinstr, i_instr_rdinstrh,
    input  logic i_instr_ecall_ebreak, i_instr_getq, i_instr_setq, i_instr_retirq,
    input  logic i_instr_maskirq, i_instr_waitirq, i_instr_timer, i_instr_trap,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_next_pc,
    input  logic i_dbg_next,
    output logic ev_lui, ev_auipc, ev_jal, ev_jalr,
    output logic ev_beq, ev_bne, ev_blt, ev_bge, ev_bltu, ev_bgeu,
    output logic ev_lb, ev_lh, ev_lw, ev_lbu, ev_lhu,
    output logic ev_sb, ev_sh, ev_sw,
    output logic ev_addi, ev_slti, ev_sltiu, ev_xori, ev_ori,
    output logic ev_andi, ev_slli, ev_srli, ev_srai,
    output logic ev_add, ev_sub, ev_sll, ev_slt, ev_sltu,
    output logic ev_xor, ev_srl, ev_sra, ev_or, ev_and,
    output logic ev_rdcycle, ev_rdcycleh, ev_rdinstr, ev_rdinstrh,
    output logic ev_ecall_ebreak, ev_getq, ev_setq, ev_retirq,
    output logic ev_maskirq, ev_waitirq, ev_timer, ev_trap,
    output logic ev_branch, ev_jump, ev_load, ev_store, ev_alu, ev_csr, ev_irq,
    output logic ev_nonseq,
    output logic ev_onehot_err,
    output logic ev_unknown,
    output logic [CNT_W-1:0] o_instr_cnt
);
    localparam int unsigned N_EV = 49;
    localparam int unsigned PC_W = 32;

    logic [N_EV-1:0] flags;
    logic [N_EV-1:0] ev_q;
    logic [PC_W-1:0] last_pc;
    logic            last_vld;
    logic [PC_W-1:0] pc_delta;
    logic            multi_hot;
    logic            unused_next_pc;

    // Bit index follows decode order: lui=0 ... trap=48
    assign flags = {i_instr_trap, i_instr_timer, i_instr_waitirq, i_instr_maskirq, i_instr_retirq,
                    i_instr_setq, i_instr_getq, i_instr_ecall_ebreak, i_instr_rdinstrh, i_instr_rdinstr,
                    i_instr_rdcycleh, i_instr_rdcycle, i_instr_and, i_instr_or, i_instr_sra,
                    i_instr_srl, i_instr_xor, i_instr_sltu, i_instr_slt, i_instr_sll,
                    i_instr_sub, i_instr_add, i_instr_srai, i_instr_srli, i_instr_slli,
                    i_instr_andi, i_instr_ori, i_instr_xori, i_instr_sltiu, i_instr_slti,
                    i_instr_addi, i_instr_sw, i_instr_sh, i_instr_sb, i_instr_lhu,
                    i_instr_lbu, i_instr_lw, i_instr_lh, i_instr_lb, i_instr_bgeu,
                    i_instr_bltu, i_instr_bge, i_instr_blt, i_instr_bne, i_instr_beq,
                    i_instr_jalr, i_instr_jal, i_instr_auipc, i_instr_lui};

    assign {ev_trap, ev_timer, ev_waitirq, ev_maskirq, ev_retirq,
            ev_setq, ev_getq, ev_ecall_ebreak, ev_rdinstrh, ev_rdinstr,
            ev_rdcycleh, ev_rdcycle, ev_and, ev_or, ev_sra,
            ev_srl, ev_xor, ev_sltu, ev_slt, ev_sll,
            ev_sub, ev_add, ev_srai, ev_srli, ev_slli,
            ev_andi, ev_ori, ev_xori, ev_sltiu, ev_slti,
            ev_addi, ev_sw, ev_sh, ev_sb, ev_lhu,
            ev_lbu, ev_lw, ev_lh, ev_lb, ev_bgeu,
            ev_bltu, ev_bge, ev_blt, ev_bne, ev_beq,
            ev_jalr, ev_jal, ev_auipc, ev_lui} = ev_q;

    // Clearing the lowest set bit leaves something only when two or more flags are set
    assign multi_hot = |(flags & (flags - N_EV'(1)));
    assign pc_delta  = i_pc - last_pc;

    // Next-PC is observed for debug only
    assign unused_next_pc = ^i_next_pc;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ev_q          <= '0;
            ev_branch     <= 1'b0;
            ev_jump       <= 1'b0;
            ev_load       <= 1'b0;
            ev_store      <= 1'b0;
            ev_alu        <= 1'b0;
            ev_csr        <= 1'b0;
            ev_irq        <= 1'b0;
            ev_nonseq     <= 1'b0;
            ev_onehot_err <= 1'b0;
            ev_unknown    <= 1'b0;
            last_pc       <= '0;
            last_vld      <= 1'b0;
        end else begin
            ev_q          <= flags & {N_EV{i_dbg_next}};
            ev_branch     <= i_dbg_next & (|flags[9:4]);
            ev_jump       <= i_dbg_next & (|flags[3:2]);
            ev_load       <= i_dbg_next & (|flags[14:10]);
            ev_store      <= i_dbg_next & (|flags[17:15]);
            ev_alu        <= i_dbg_next & ((|flags[1:0]) | (|flags[36:18]));
            ev_csr        <= i_dbg_next & (|flags[40:37]);
            ev_irq        <= i_dbg_next & (|flags[47:42]);
            ev_nonseq     <= i_dbg_next & last_vld &
                             (pc_delta != PC_W'(2)) & (pc_delta != PC_W'(4));
            ev_onehot_err <= i_dbg_next & multi_hot;
            ev_unknown    <= i_dbg_next & ~(|flags);
            if (i_dbg_next) begin
                last_pc  <= i_pc;
                last_vld <= 1'b1;
            end
        end
    end

`ifdef RISCVSYS_EVMON_COUNT_EN
    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_instr_cnt <= '0;
        end else if (i_dbg_next) begin
            o_instr_cnt <= o_instr_cnt + CNT_W'(1);
        end
    end
`else
    assign o_instr_cnt = '0;
`endif

endmodule

// File: tb/tb_riscvsys_evmon.sv
// Directed self-checking bench for riscvsys_evmon (CNT_W=4 to exercise counter wrap).
module tb_riscvsys_evmon;
    localparam int unsigned CNT_W = 4;

    logic              clk;
    logic              rst;
    logic [48:0]       fl;
    logic [31:0]       pc;
    logic [31:0]       next_pc;
    logic              dbg;
    wire  [48:0]       ev;
    wire               ev_branch, ev_jump, ev_load, ev_store, ev_alu, ev_csr, ev_irq;
    wire               ev_nonseq, ev_onehot_err, ev_unknown;
    wire  [CNT_W-1:0]  cnt;
    wire  [6:0]        cls;

    int n_tot = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    assign cls = {ev_irq, ev_csr, ev_alu, ev_store, ev_load, ev_jump, ev_branch};

    riscvsys_evmon #(.CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_instr_lui(fl[0]), .i_instr_auipc(fl[1]), .i_instr_jal(fl[2]), .i_instr_jalr(fl[3]),
        .i_instr_beq(fl[4]), .i_instr_bne(fl[5]), .i_instr_blt(fl[6]), .i_instr_bge(fl[7]),
        .i_instr_bltu(fl[8]), .i_instr_bgeu(fl[9]), .i_instr_lb(fl[10]), .i_instr_lh(fl[11]),
        .i_instr_lw(fl[12]), .i_instr_lbu(fl[13]), .i_instr_lhu(fl[14]), .i_instr_sb(fl[15]),
        .i_instr_sh(fl[16]), .i_instr_sw(fl[17]), .i_instr_addi(fl[18]), .i_instr_slti(fl[19]),
        .i_instr_sltiu(fl[20]), .i_instr_xori(fl[21]), .i_instr_ori(fl[22]), .i_instr_andi(fl[23]),
        .i_instr_slli(fl[24]), .i_instr_srli(fl[25]), .i_instr_srai(fl[26]), .i_instr_add(fl[27]),
        .i_instr_sub(fl[28]), .i_instr_sll(fl[29]), .i_instr_slt(fl[30]), .i_instr_sltu(fl[31]),
        .i_instr_xor(fl[32]), .i_instr_srl(fl[33]), .i_instr_sra(fl[34]), .i_instr_or(fl[35]),
        .i_instr_and(fl[36]), .i_instr_rdcycle(fl[37]), .i_instr_rdcycleh(fl[38]),
        .i_instr_rdinstr(fl[39]), .i_instr_rdinstrh(fl[40]), .i_instr_ecall_ebreak(fl[41]),
        .i_instr_getq(fl[42]), .i_instr_setq(fl[43]), .i_instr_retirq(fl[44]),
        .i_instr_maskirq(fl[45]), .i_instr_waitirq(fl[46]), .i_instr_timer(fl[47]),
        .i_instr_trap(fl[48]),
        .i_pc(pc), .i_next_pc(next_pc), .i_dbg_next(dbg),
        .ev_lui(ev[0]), .ev_auipc(ev[1]), .ev_jal(ev[2]), .ev_jalr(ev[3]),
        .ev_beq(ev[4]), .ev_bne(ev[5]), .ev_blt(ev[6]), .ev_bge(ev[7]),
        .ev_bltu(ev[8]), .ev_bgeu(ev[9]), .ev_lb(ev[10]), .ev_lh(ev[11]),
        .ev_lw(ev[12]), .ev_lbu(ev[13]), .ev_lhu(ev[14]), .ev_sb(ev[15]),
        .ev_sh(ev[16]), .ev_sw(ev[17]), .ev_addi(ev[18]), .ev_slti(ev[19]),
        .ev_sltiu(ev[20]), .ev_xori(ev[21]), .ev_ori(ev[22]), .ev_andi(ev[23]),
        .ev_slli(ev[24]), .ev_srli(ev[25]), .ev_srai(ev[26]), .ev_add(ev[27]),
        .ev_sub(ev[28]), .ev_sll(ev[29]), .ev_slt(ev[30]), .ev_sltu(ev[31]),
        .ev_xor(ev[32]), .ev_srl(ev[33]), .ev_sra(ev[34]), .ev_or(ev[35]),
        .ev_and(ev[36]), .ev_rdcycle(ev[37]), .ev_rdcycleh(ev[38]),
        .ev_rdinstr(ev[39]), .ev_rdinstrh(ev[40]), .ev_ecall_ebreak(ev[41]),
        .ev_getq(ev[42]), .ev_setq(ev[43]), .ev_retirq(ev[44]),
        .ev_maskirq(ev[45]), .ev_waitirq(ev[46]), .ev_timer(ev[47]), .ev_trap(ev[48]),
        .ev_branch(ev_branch), .ev_jump(ev_jump), .ev_load(ev_load), .ev_store(ev_store),
        .ev_alu(ev_alu), .ev_csr(ev_csr), .ev_irq(ev_irq),
        .ev_nonseq(ev_nonseq), .ev_onehot_err(ev_onehot_err), .ev_unknown(ev_unknown),
        .o_instr_cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected counter value; tied to zero when the counter is not built
    function automatic logic [CNT_W-1:0] ecnt();
`ifdef RISCVSYS_EVMON_COUNT_EN
        return CNT_W'(exp_cnt);
`else
        return '0;
`endif
    endfunction

    // Expected class vector {irq,csr,alu,store,load,jump,branch} for a single flag index
    function automatic logic [6:0] cls_of(int i);
        logic [6:0] c;
        c = '0;
        if (i >= 4 && i <= 9)                 c[0] = 1'b1;
        if (i == 2 || i == 3)                 c[1] = 1'b1;
        if (i >= 10 && i <= 14)               c[2] = 1'b1;
        if (i >= 15 && i <= 17)               c[3] = 1'b1;
        if (i <= 1 || (i >= 18 && i <= 36))   c[4] = 1'b1;
        if (i >= 37 && i <= 40)               c[5] = 1'b1;
        if (i >= 42 && i <= 47)               c[6] = 1'b1;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; dbg = 1'b0; fl = '0;
        step();
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; fl = '1; dbg = 1'b1; pc = 32'h40;
        step(); step();
        n_tot++; if (ev !== 49'd0) begin n_bad++; $display("FAIL reset_ev got=%h want=0", ev); end
        n_tot++; if (cls !== 7'd0) begin n_bad++; $display("FAIL reset_cls got=%h want=0", cls); end
        n_tot++; if ({ev_nonseq, ev_onehot_err, ev_unknown} !== 3'b000) begin
            n_bad++; $display("FAIL reset_misc got=%b want=000", {ev_nonseq, ev_onehot_err, ev_unknown}); end
        n_tot++; if (cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        rst = 1'b1; fl = '0; dbg = 1'b0;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_single_add();
        logic [48:0] e;
        e = '0; e[27] = 1'b1;
        fl = '0; fl[27] = 1'b1; dbg = 1'b1; pc = 32'h100;
        step(); exp_cnt++;
        fl = '0; dbg = 1'b0;
        n_tot++; if (ev !== e) begin n_bad++; $display("FAIL add_ev got=%h want=%h", ev, e); end
        n_tot++; if (cls !== 7'b0010000) begin n_bad++; $display("FAIL add_cls got=%b want=0010000", cls); end
        n_tot++; if ({ev_nonseq, ev_onehot_err, ev_unknown} !== 3'b000) begin
            n_bad++; $display("FAIL add_misc got=%b want=000", {ev_nonseq, ev_onehot_err, ev_unknown}); end
        n_tot++; if (cnt !== ecnt()) begin n_bad++; $display("FAIL add_cnt got=%0d want=%0d", cnt, ecnt()); end
        step();
        n_tot++; if (ev !== 49'd0 || cls !== 7'd0) begin
            n_bad++; $display("FAIL add_pulse_end got=%h/%b want=0", ev, cls); end
    endtask

    task automatic test_unqualified();
        fl = '0; fl[4] = 1'b1; dbg = 1'b0; pc = 32'h300;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tot++; if (ev !== 49'd0 || cls !== 7'd0 || ev_unknown !== 1'b0) begin
                n_bad++; $display("FAIL unqual_ev[%0d] got=%h/%b want=0", k, ev, cls); end
            n_tot++; if (cnt !== ecnt()) begin
                n_bad++; $display("FAIL unqual_cnt[%0d] got=%0d want=%0d", k, cnt, ecnt()); end
        end
        fl = '0;
    endtask

    task automatic test_nonseq();
        logic [31:0] pcs [0:6];
        logic        exp_ns [0:6];
        pcs = '{32'h100, 32'h104, 32'h106, 32'h200, 32'h200, 32'hFFFF_FFFE, 32'h0000_0002};
        exp_ns = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        fl = '0; fl[27] = 1'b1; dbg = 1'b1;
        for (int k = 0; k < 7; k++) begin
            pc = pcs[k];
            step(); exp_cnt++;
            n_tot++; if (ev_nonseq !== exp_ns[k]) begin
                n_bad++; $display("FAIL nonseq[%0d] pc=%h got=%b want=%b", k, pcs[k], ev_nonseq, exp_ns[k]); end
            if (k == 3) begin
                n_tot++; if (cnt !== ecnt()) begin
                    n_bad++; $display("FAIL nonseq_cnt got=%0d want=%0d", cnt, ecnt()); end
            end
        end
        dbg = 1'b0; fl = '0;
        step();
    endtask

    task automatic test_multi_unknown();
        logic [48:0] e;
        e = '0; e[12] = 1'b1; e[17] = 1'b1;
        fl = '0; fl[12] = 1'b1; fl[17] = 1'b1; dbg = 1'b1; pc = 32'h6;
        step(); exp_cnt++;
        n_tot++; if (ev !== e) begin n_bad++; $display("FAIL multi_ev got=%h want=%h", ev, e); end
        n_tot++; if (cls !== 7'b0001100) begin n_bad++; $display("FAIL multi_cls got=%b want=0001100", cls); end
        n_tot++; if (ev_onehot_err !== 1'b1 || ev_unknown !== 1'b0) begin
            n_bad++; $display("FAIL multi_err got=%b%b want=10", ev_onehot_err, ev_unknown); end
        fl = '0; pc = 32'hA;
        step(); exp_cnt++;
        n_tot++; if (ev_unknown !== 1'b1 || ev_onehot_err !== 1'b0 || ev !== 49'd0 || cls !== 7'd0) begin
            n_bad++; $display("FAIL unknown got=%b%b ev=%h want=10 ev=0", ev_unknown, ev_onehot_err, ev); end
        n_tot++; if (cnt !== ecnt()) begin n_bad++; $display("FAIL unknown_cnt got=%0d want=%0d", cnt, ecnt()); end
        dbg = 1'b0;
        step();
    endtask

    task automatic test_classes();
        logic [48:0] e;
        do_reset();
        dbg = 1'b1;
        for (int i = 0; i < 49; i++) begin
            fl = '0; fl[i] = 1'b1; pc = 32'h1000 + 32'(i * 4);
            e = '0; e[i] = 1'b1;
            step(); exp_cnt++;
            n_tot++; if (ev !== e || cls !== cls_of(i)) begin
                n_bad++; $display("FAIL class[%0d] got=%h/%b want=%h/%b", i, ev, cls, e, cls_of(i)); end
            n_tot++; if ({ev_nonseq, ev_onehot_err, ev_unknown} !== 3'b000) begin
                n_bad++; $display("FAIL class_misc[%0d] got=%b want=000", i, {ev_nonseq, ev_onehot_err, ev_unknown}); end
        end
        dbg = 1'b0; fl = '0;
        step();
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        fl = '0; fl[27] = 1'b1; dbg = 1'b1;
        for (int k = 0; k < 17; k++) begin
            pc = 32'h2000 + 32'(k * 4);
            step(); exp_cnt++;
        end
        n_tot++; if (cnt !== ecnt()) begin n_bad++; $display("FAIL wrap_cnt got=%0d want=%0d", cnt, ecnt()); end
        rst = 1'b0; pc = 32'h3000;
        step(); exp_cnt = 0;
        n_tot++; if (ev !== 49'd0 || cls !== 7'd0 || ev_nonseq !== 1'b0) begin
            n_bad++; $display("FAIL midrst_ev got=%h/%b want=0", ev, cls); end
        n_tot++; if (cnt !== '0) begin n_bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt); end
        rst = 1'b1; dbg = 1'b0; fl = '0;
        step();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        do_reset();
        fl = '0; fl[12] = 1'b1; dbg = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pc = 32'h400 + 32'(k * 4);
            step(); exp_cnt++;
            if (ev[12] === 1'b1 && ev_load === 1'b1) pulses++;
        end
        dbg = 1'b0; fl = '0;
        step();
        n_tot++; if (ev[12] !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got=%b want=0", ev[12]); end
        n_tot++; if (pulses != 5) begin n_bad++; $display("FAIL b2b_pulses got=%0d want=5", pulses); end
        n_tot++; if (cnt !== ecnt()) begin n_bad++; $display("FAIL b2b_cnt got=%0d want=%0d", cnt, ecnt()); end
    endtask

    initial begin
        rst = 1'b0; fl = '0; pc = '0; next_pc = 32'hDEAD_BEEF; dbg = 1'b0;
        test_reset();
        test_single_add();
        test_unqualified();
        test_nonseq();
        test_multi_unknown();
        test_classes();
        test_wrap_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
